// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO feeding the 16x16 register file write port.
// Define WB_FORWARD_EN to compile in the pending-write forwarding lookup.
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [ADDR_W-1:0]         mem_dst,
    input  logic [DATA_W-1:0]         mem_data,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [ADDR_W-1:0]         alu_dst,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      hold,
    output logic [ADDR_W-1:0]         dst_reg,
    output logic [DATA_W-1:0]         dst_data,
    output logic                      write_reg,
    input  logic [ADDR_W-1:0]         q_reg1,
    input  logic [ADDR_W-1:0]         q_reg2,
    output logic                      q_hit1,
    output logic                      q_hit2,
    output logic [DATA_W-1:0]         q_data1,
    output logic [DATA_W-1:0]         q_data2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] dst_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic              not_full;
    logic              acc_mem;
    logic              acc_alu;
    logic [ADDR_W-1:0] acc_dst;
    logic [DATA_W-1:0] acc_data;
    logic              push;
    logic              pop;

    assign not_full  = (count < FULL);
    assign mem_ready = not_full;
    // Memory result belongs to the older instruction, so it always wins.
    assign alu_ready = not_full && !mem_valid;

    assign acc_mem  = mem_valid && mem_ready;
    assign acc_alu  = alu_valid && alu_ready;
    assign acc_dst  = acc_mem ? mem_dst  : alu_dst;
    assign acc_data = acc_mem ? mem_data : alu_data;
    assign push     = (acc_mem || acc_alu) && (acc_dst != '0);
    assign pop      = !hold && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            dst_mem[tail]  <= acc_dst;
            data_mem[tail] <= acc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            write_reg <= 1'b0;
            dst_reg   <= '0;
            dst_data  <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head      <= head + PTR_W'(1);
                dst_reg   <= dst_mem[head];
                dst_data  <= data_mem[head];
                write_reg <= 1'b1;
            end else begin
                write_reg <= 1'b0;
            end
            unique case (1'b1)
                push && !pop: count <= count + CNT_W'(1);
                pop && !push: count <= count - CNT_W'(1);
                default:      count <= count;
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest so the last match left standing is the newest.
    always_comb begin
        q_hit1  = 1'b0;
        q_hit2  = 1'b0;
        q_data1 = '0;
        q_data2 = '0;
        idx     = '0;
        if (write_reg && q_reg1 != '0 && dst_reg == q_reg1) begin
            q_hit1  = 1'b1;
            q_data1 = dst_data;
        end
        if (write_reg && q_reg2 != '0 && dst_reg == q_reg2) begin
            q_hit2  = 1'b1;
            q_data2 = dst_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (q_reg1 != '0 && dst_mem[idx] == q_reg1) begin
                    q_hit1  = 1'b1;
                    q_data1 = data_mem[idx];
                end
                if (q_reg2 != '0 && dst_mem[idx] == q_reg2) begin
                    q_hit2  = 1'b1;
                    q_data2 = data_mem[idx];
                end
            end
        end
    end
`else
    logic unused_q_regs;

    assign unused_q_regs = ^{q_reg1, q_reg2};
    assign q_hit1  = 1'b0;
    assign q_hit2  = 1'b0;
    assign q_data1 = '0;
    assign q_data2 = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed vector bench for reg_writeback_queue.
// Forwarding expectations follow whether WB_FORWARD_EN is defined.
module tb_reg_writeback_queue;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_dst;
    logic [15:0] mem_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_dst;
    logic [15:0] alu_data;
    logic        hold;
    logic [3:0]  dst_reg;
    logic [15:0] dst_data;
    logic        write_reg;
    logic [3:0]  q_reg1;
    logic [3:0]  q_reg2;
    logic        q_hit1;
    logic        q_hit2;
    logic [15:0] q_data1;
    logic [15:0] q_data2;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;

    reg_writeback_queue #(.DEPTH(4), .DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_dst(mem_dst), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_dst(alu_dst), .alu_data(alu_data),
        .hold(hold),
        .dst_reg(dst_reg), .dst_data(dst_data), .write_reg(write_reg),
        .q_reg1(q_reg1), .q_reg2(q_reg2),
        .q_hit1(q_hit1), .q_hit2(q_hit2),
        .q_data1(q_data1), .q_data2(q_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv;
        logic [3:0]  md;
        logic [15:0] mdat;
        logic        av;
        logic [3:0]  ad;
        logic [15:0] adat;
        logic        hold;
        logic        mr;
        logic        ar;
        logic        wr;
        logic [3:0]  dr;
        logic [15:0] dd;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0;
        mem_dst   = '0;
        mem_data  = '0;
        alu_valid = 1'b0;
        alu_dst   = '0;
        alu_data  = '0;
    endtask

    initial begin
        // mv md mdat   av ad adat   hold | mr ar wr dr dd cnt
        vecs.push_back('{0,4'h0,16'h0000,1,4'h3,16'h1234,0, 1,1,0,4'h0,16'h0000,3'd1});
        vecs.push_back('{0,4'h0,16'h0000,0,4'h0,16'h0000,0, 1,1,1,4'h3,16'h1234,3'd0});
        vecs.push_back('{0,4'h0,16'h0000,0,4'h0,16'h0000,0, 1,1,0,4'h3,16'h1234,3'd0});
        vecs.push_back('{1,4'h5,16'hAAAA,1,4'h6,16'h5555,0, 1,0,0,4'h3,16'h1234,3'd1});
        vecs.push_back('{0,4'h0,16'h0000,1,4'h6,16'h5555,0, 1,1,1,4'h5,16'hAAAA,3'd1});
        vecs.push_back('{0,4'h0,16'h0000,0,4'h0,16'h0000,0, 1,1,1,4'h6,16'h5555,3'd0});
        vecs.push_back('{0,4'h0,16'h0000,0,4'h0,16'h0000,0, 1,1,0,4'h6,16'h5555,3'd0});
        vecs.push_back('{0,4'h0,16'h0000,1,4'h1,16'h0011,1, 1,1,0,4'h6,16'h5555,3'd1});
        vecs.push_back('{1,4'h2,16'h0022,0,4'h0,16'h0000,1, 1,0,0,4'h6,16'h5555,3'd2});
        vecs.push_back('{0,4'h0,16'h0000,1,4'h3,16'h0033,1, 1,1,0,4'h6,16'h5555,3'd3});
        vecs.push_back('{1,4'h4,16'h0044,0,4'h0,16'h0000,1, 1,0,0,4'h6,16'h5555,3'd4});
        vecs.push_back('{0,4'h0,16'h0000,1,4'h5,16'h0055,1, 0,0,0,4'h6,16'h5555,3'd4});
        vecs.push_back('{0,4'h0,16'h0000,1,4'h5,16'h0055,0, 0,0,1,4'h1,16'h0011,3'd3});
        vecs.push_back('{0,4'h0,16'h0000,1,4'h5,16'h0055,0, 1,1,1,4'h2,16'h0022,3'd3});
        vecs.push_back('{0,4'h0,16'h0000,0,4'h0,16'h0000,0, 1,1,1,4'h3,16'h0033,3'd2});
        vecs.push_back('{0,4'h0,16'h0000,0,4'h0,16'h0000,0, 1,1,1,4'h4,16'h0044,3'd1});
        vecs.push_back('{0,4'h0,16'h0000,0,4'h0,16'h0000,0, 1,1,1,4'h5,16'h0055,3'd0});
        vecs.push_back('{0,4'h0,16'h0000,0,4'h0,16'h0000,0, 1,1,0,4'h5,16'h0055,3'd0});
        vecs.push_back('{0,4'h0,16'h0000,1,4'h0,16'hFFFF,0, 1,1,0,4'h5,16'h0055,3'd0});
        vecs.push_back('{0,4'h0,16'h0000,0,4'h0,16'h0000,0, 1,1,0,4'h5,16'h0055,3'd0});
        vecs.push_back('{1,4'h0,16'hFFFF,0,4'h0,16'h0000,0, 1,0,0,4'h5,16'h0055,3'd0});
        vecs.push_back('{0,4'h0,16'h0000,0,4'h0,16'h0000,0, 1,1,0,4'h5,16'h0055,3'd0});

        rst    = 1'b0;
        hold   = 1'b0;
        q_reg1 = '0;
        q_reg2 = '0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("reset count", 32'(count), 0);
        check("reset write_reg", 32'(write_reg), 0);
        check("reset dst_reg", 32'(dst_reg), 0);
        check("reset dst_data", 32'(dst_data), 0);
        check("reset mem_ready", 32'(mem_ready), 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v         = vecs[i];
            mem_valid = v.mv;
            mem_dst   = v.md;
            mem_data  = v.mdat;
            alu_valid = v.av;
            alu_dst   = v.ad;
            alu_data  = v.adat;
            hold      = v.hold;
            #1;
            check($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(v.mr));
            check($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(v.ar));
            tick();
            check($sformatf("v%0d write_reg", i), 32'(write_reg), 32'(v.wr));
            check($sformatf("v%0d dst_reg", i), 32'(dst_reg), 32'(v.dr));
            check($sformatf("v%0d dst_data", i), 32'(dst_data), 32'(v.dd));
            check($sformatf("v%0d count", i), 32'(count), 32'(v.cnt));
        end

        // Two pending writes to R7 while held: lookup returns the newer one.
        idle_inputs();
        hold      = 1'b1;
        alu_valid = 1'b1;
        alu_dst   = 4'h7;
        alu_data  = 16'h0001;
        tick();
        alu_data  = 16'h0002;
        tick();
        idle_inputs();
        q_reg1 = 4'h7;
        q_reg2 = 4'h0;
        #1;
        check("fwd count", 32'(count), 2);
        check("fwd hit1 queued", 32'(q_hit1), 32'(FWD));
        check("fwd data1 youngest", 32'(q_data1), FWD ? 32'h2 : 32'h0);
        check("fwd r0 hit2", 32'(q_hit2), 0);
        check("fwd r0 data2", 32'(q_data2), 0);
        q_reg2 = 4'h9;
        #1;
        check("fwd miss hit2", 32'(q_hit2), 0);
        check("fwd miss data2", 32'(q_data2), 0);
        hold = 1'b0;
        tick();
        check("fwd drain1 write_reg", 32'(write_reg), 1);
        check("fwd drain1 dst_data", 32'(dst_data), 32'h1);
        check("fwd drain1 hit1", 32'(q_hit1), 32'(FWD));
        check("fwd drain1 data1", 32'(q_data1), FWD ? 32'h2 : 32'h0);
        tick();
        check("fwd drain2 count", 32'(count), 0);
        check("fwd drain2 dst_data", 32'(dst_data), 32'h2);
        check("fwd port hit1", 32'(q_hit1), 32'(FWD));
        check("fwd port data1", 32'(q_data1), FWD ? 32'h2 : 32'h0);
        tick();
        check("fwd idle write_reg", 32'(write_reg), 0);
        check("fwd idle hit1", 32'(q_hit1), 0);
        check("fwd idle data1", 32'(q_data1), 0);
        q_reg1 = '0;
        q_reg2 = '0;

        // Reset lands with three entries queued and a write in flight.
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1'b1;
            alu_dst   = 4'(i);
            alu_data  = 16'(16'h0100 * i);
            tick();
        end
        idle_inputs();
        check("pre-reset full count", 32'(count), 4);
        hold = 1'b0;
        tick();
        check("pre-reset write_reg", 32'(write_reg), 1);
        check("pre-reset dst_reg", 32'(dst_reg), 1);
        check("pre-reset count", 32'(count), 3);
        rst = 1'b0;
        tick();
        check("mid reset count", 32'(count), 0);
        check("mid reset write_reg", 32'(write_reg), 0);
        check("mid reset dst_reg", 32'(dst_reg), 0);
        check("mid reset dst_data", 32'(dst_data), 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post reset %0d write_reg", i), 32'(write_reg), 0);
            check($sformatf("post reset %0d count", i), 32'(count), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-side companion of the 16x16 register file: collects destination results from the ALU and memory-load paths, buffers them in a small in-order FIFO, and drains at most one entry per cycle onto the register file write port (`dst_reg`/`dst_data`/`write_reg`). It also provides a forwarding lookup, so decode can read values that are still pending in the queue or in flight on the write port. Writes to R0 are accepted and discarded, matching the hardwired-zero R0 of the register file.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `DATA_W`, 16: data width.
- `ADDR_W`, 4: register index width.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset (asserted when 0).
- `mem_valid` in 1: memory-load result offered.
- `mem_ready` out 1: queue can accept a memory result.
- `mem_dst` in ADDR_W: destination register of the memory result.
- `mem_data` in DATA_W: memory result data.
- `alu_valid` in 1: ALU result offered.
- `alu_ready` out 1: queue can accept an ALU result.
- `alu_dst` in ADDR_W: destination register of the ALU result.
- `alu_data` in DATA_W: ALU result data.
- `hold` in 1: when 1, the queue does not drain.
- `dst_reg` out ADDR_W: registered write index to the register file.
- `dst_data` out DATA_W: registered write data.
- `write_reg` out 1: registered write enable.
- `q_reg1`, `q_reg2` in ADDR_W: forwarding lookup indices.
- `q_hit1`, `q_hit2` out 1: a pending write to the looked-up register exists.
- `q_data1`, `q_data2` out DATA_W: newest pending value for the looked-up register.
- `count` out clog2(DEPTH)+1: number of occupied entries.

## Operation
- Circular FIFO with head/tail pointers and an occupancy counter. Pointers wrap modulo DEPTH.
- Ready signals:
  - `mem_ready = (count < DEPTH)`.
  - `alu_ready = (count < DEPTH) && !mem_valid`.
  - Memory has fixed priority because its instruction is older.
  - Readiness uses the registered `count` only; a same-cycle drain does not free a slot for the same cycle.
- Accept: a result is accepted when `valid && ready`, with at most one accept per cycle.
  - If the accepted destination is 0, nothing is enqueued and `count` is unchanged.
  - Otherwise the entry `{dst, data}` is written at the tail and the tail advances.
- Drain: at each edge, if `hold` = 0 and `count` > 0, the head entry is loaded into `dst_reg`/`dst_data`, `write_reg` goes to 1, and the head advances.
  - Otherwise `write_reg` goes to 0, and `dst_reg`/`dst_data` hold their last values.
- Simultaneous accept and drain: `count` is unchanged and both pointers advance.
- Forwarding, combinational:
  - `q_hitN` = 1 if `q_regN` != 0 and it matches any occupied entry, or matches `dst_reg` while `write_reg` = 1.
  - `q_dataN` is the youngest queue match if one exists, else `dst_data` on a write-port match, else 0.
  - Looking up R0 always gives hit 0, data 0.
- Order is strictly preserved: multiple pending writes to one register reach the register file oldest-first.

## Timing
- Reset (`rst` = 0 at an edge): `count` = 0, pointers = 0, `write_reg` = 0, `dst_reg` = 0, `dst_data` = 0. Queue contents are discarded. The block applies this even with entries pending or a write in flight.
- Latency from an accept at edge N, with an empty queue and `hold` = 0:
  - `write_reg` = 1 during the cycle after edge N+1.
  - The register file commits the write at edge N+2.
- Throughput: one write per cycle when not held.
- Full (`count` = DEPTH): both ready signals are 0; no data is lost.
- Empty: `write_reg` = 0.
- `hold` asserted: entries retain order and accepts continue until the queue is full.
- Forwarding outputs reflect state as of the current cycle, before that cycle's edge updates.

## Configuration
- `WB_FORWARD_EN` defined: the forwarding match logic is compiled in, as described above.
- Not defined: the match logic is removed; `q_hit1`/`q_hit2` are tied to 0 and `q_data1`/`q_data2` to 0. Ports remain present.

## Test plan
- Reset, then an ALU accept of R3=0x1234 with `hold` = 0 -> `write_reg` = 1 with `dst_reg` = 3, `dst_data` = 0x1234 exactly one cycle after the accept edge; `count` returns to 0.
- `mem_valid` and `alu_valid` both high, with R5=0xAAAA (mem) and R6=0x5555 (alu) -> `alu_ready` = 0 and the mem result is accepted first. Holding `alu_valid` high, the next cycle accepts R6. Writes come out as R5 then R6.
- `hold` = 1 with 4 accepts (R1..R4) -> `count` = 4, `mem_ready` = `alu_ready` = 0, and a 5th offer is stalled. Releasing `hold` gives four back-to-back writes in R1..R4 order.
- Accept R0=0xFFFF -> `count` stays 0, `write_reg` never asserts, and a lookup of `q_reg1` = 0 gives hit 0, data 0.
- With `WB_FORWARD_EN`, `hold` = 1, enqueue R7=0x0001 then R7=0x0002 -> `q_reg1` = 7 gives `q_hit1` = 1, `q_data1` = 0x0002. Without the macro, `q_hit1` = 0.
- `rst` = 0 with 3 entries pending and `write_reg` = 1 -> after the edge `count` = 0 and `write_reg` = 0, and no further writes occur.
